// File: rtl/jt12_acc_seq_pkg.sv
// jt12_acc_seq_pkg: shared constants and types for the accumulator slot sequencer
package jt12_acc_seq_pkg;
  localparam int NUM_CH = 6;
  localparam int NUM_SLOT = 24;
  localparam logic [1:0] GRP_S1 = 2'd0;
  localparam logic [1:0] GRP_S3 = 2'd1;
  localparam logic [1:0] GRP_S2 = 2'd2;
  localparam logic [1:0] GRP_S4 = 2'd3;
  typedef struct packed {
    logic [2:0] alg;
    logic [1:0] rl;
  } ch_cfg_t;
  localparam logic [2:0] ALG_RST = 3'd0;
  localparam logic [1:0] RL_RST_DEF = 2'b11;
  localparam logic PCM_RST = 1'b0;
endpackage

// File: rtl/jt12_slot_cnt.sv
// jt12_slot_cnt: {grp, ch} slot counter with registered strobe, ch6op and frame_start decode
module jt12_slot_cnt
  import jt12_acc_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  output logic [2:0] ch_o,
  output logic [2:0] ch_nxt_o,
  output logic [1:0] grp_nxt_o,
  output logic [3:0] strb_o,
  output logic       ch6op_o,
  output logic       frame_start_o
);
  logic [2:0] ch_q, ch_d;
  logic [1:0] grp_q, grp_d;
  logic [3:0] strb_q;
  logic       ch6op_q, frame_q;
  always_comb begin
    ch_d = !clk_en ? ch_q : ch_q == 3'(NUM_CH - 1) ? 3'd0 : ch_q + 3'd1;
    grp_d = clk_en && ch_q == 3'(NUM_CH - 1) ? grp_q + 2'd1 : grp_q;
  end
  // decode from next-state so each flag lands in the slot it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q <= 3'd0;
      grp_q <= GRP_S1;
      strb_q <= 4'b0001;
      ch6op_q <= 1'b0;
      frame_q <= 1'b1;
    end else begin
      ch_q <= ch_d;
      grp_q <= grp_d;
      strb_q <= 4'b0001 << grp_d;
      ch6op_q <= ch_d == 3'(NUM_CH - 1);
      frame_q <= ch_d == 3'd0 && grp_d == GRP_S1;
    end
  end
  assign ch_o = ch_q;
  assign ch_nxt_o = ch_d;
  assign grp_nxt_o = grp_d;
  assign strb_o = strb_q;
  assign ch6op_o = ch6op_q;
  assign frame_start_o = frame_q;
endmodule

// File: rtl/jt12_acc_seq.sv
// jt12_acc_seq: operator slot sequencer with per-channel config table
// whose host writes are deferred to the channel's first S3 slot.
module jt12_acc_seq #(
  parameter int         NUM_CH = jt12_acc_seq_pkg::NUM_CH,
  parameter logic [1:0] RL_RST = jt12_acc_seq_pkg::RL_RST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [1:0] cfg_rl,
  input  logic       cfg_pcm,
  output logic       cfg_busy,
  output logic       s1_enters,
  output logic       s3_enters,
  output logic       s2_enters,
  output logic       s4_enters,
  output logic [2:0] cur_ch,
  output logic       ch6op,
  output logic [2:0] alg,
  output logic [1:0] rl,
  output logic       pcm_en,
  output logic       frame_start
);
  import jt12_acc_seq_pkg::ch_cfg_t;
  import jt12_acc_seq_pkg::GRP_S1;
  import jt12_acc_seq_pkg::GRP_S3;
  import jt12_acc_seq_pkg::GRP_S2;
  import jt12_acc_seq_pkg::GRP_S4;
  import jt12_acc_seq_pkg::ALG_RST;
  import jt12_acc_seq_pkg::PCM_RST;
  localparam ch_cfg_t CFG_RST = '{alg: ALG_RST, rl: RL_RST};
  logic [2:0] ch_nxt, pend_ch_q, pend_ch_d;
  logic [1:0] grp_nxt;
  logic [3:0] strb;
  ch_cfg_t    tbl_q [NUM_CH];
  ch_cfg_t    tbl_d [NUM_CH];
  ch_cfg_t    pend_q, pend_d, out_d, out_q;
  logic       pend_pcm_q, pend_pcm_d, busy_q, busy_d, pcm_q, pcm_d, pcm_en_q, pcm_en_d;
  logic       cap, commit;
  jt12_slot_cnt u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .ch_o         (cur_ch),
    .ch_nxt_o     (ch_nxt),
    .grp_nxt_o    (grp_nxt),
    .strb_o       (strb),
    .ch6op_o      (ch6op),
    .frame_start_o(frame_start)
  );
  // capture needs busy clear and commit needs busy set, so they never coincide
  always_comb begin
    cap = cfg_we && !busy_q && cfg_ch < 3'(NUM_CH);
    commit = clk_en && busy_q && grp_nxt == GRP_S3 && ch_nxt == pend_ch_q;
    for (int i = 0; i < NUM_CH; i++) tbl_d[i] = commit && pend_ch_q == 3'(i) ? pend_q : tbl_q[i];
    pcm_d = commit && pend_ch_q == 3'(NUM_CH - 1) ? pend_pcm_q : pcm_q;
    busy_d = commit ? 1'b0 : cap ? 1'b1 : busy_q;
    pend_d = cap ? '{alg: cfg_alg, rl: cfg_rl} : pend_q;
    pend_ch_d = cap ? cfg_ch : pend_ch_q;
    pend_pcm_d = cap ? cfg_pcm : pend_pcm_q;
    out_d = tbl_d[ch_nxt];
    pcm_en_d = ch_nxt == 3'(NUM_CH - 1) && pcm_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) tbl_q[i] <= CFG_RST;
      pcm_q <= PCM_RST;
      busy_q <= 1'b0;
      pend_q <= CFG_RST;
      pend_ch_q <= 3'd0;
      pend_pcm_q <= PCM_RST;
      out_q <= CFG_RST;
      pcm_en_q <= PCM_RST;
    end else begin
      tbl_q <= tbl_d;
      pcm_q <= pcm_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
      pend_ch_q <= pend_ch_d;
      pend_pcm_q <= pend_pcm_d;
      out_q <= out_d;
      pcm_en_q <= pcm_en_d;
    end
  end
  assign cfg_busy = busy_q;
  assign s1_enters = strb[GRP_S1];
  assign s3_enters = strb[GRP_S3];
  assign s2_enters = strb[GRP_S2];
  assign s4_enters = strb[GRP_S4];
  assign alg = out_q.alg;
  assign rl = out_q.rl;
  assign pcm_en = pcm_en_q;
endmodule

// File: tb/tb_jt12_acc_seq.sv
// tb_jt12_acc_seq: scoreboard bench; a slot-index reference model queues the
// expected output word for every clock and it is compared after the edge.
module tb_jt12_acc_seq;
  logic clk, rst, clk_en, cfg_we, cfg_pcm, cfg_busy;
  logic [2:0] cfg_ch, cfg_alg, cur_ch, alg;
  logic [1:0] cfg_rl, rl;
  logic s1_enters, s3_enters, s2_enters, s4_enters, ch6op, pcm_en, frame_start;
  int checks = 0, errors = 0;
  logic [15:0] sb[$];
  logic [15:0] got, want;
  int m_s = 0, m_pch = 0;
  logic [2:0] m_alg[6], m_pa;
  logic [1:0] m_rl[6], m_pl;
  logic m_pcm = 0, m_busy = 0, m_pp = 0;

  jt12_acc_seq dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_alg(cfg_alg), .cfg_rl(cfg_rl), .cfg_pcm(cfg_pcm), .cfg_busy(cfg_busy),
    .s1_enters(s1_enters), .s3_enters(s3_enters), .s2_enters(s2_enters),
    .s4_enters(s4_enters), .cur_ch(cur_ch), .ch6op(ch6op), .alg(alg), .rl(rl),
    .pcm_en(pcm_en), .frame_start(frame_start)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sample();
    return {cfg_busy, s1_enters, s3_enters, s2_enters, s4_enters, cur_ch, ch6op, alg, rl, pcm_en, frame_start};
  endfunction

  function automatic logic [15:0] model_out();
    int g, c;
    g = m_s / 6;
    c = m_s % 6;
    return {m_busy, g == 0, g == 1, g == 2, g == 3, 3'(c), c == 5, m_alg[c], m_rl[c], c == 5 && m_pcm, m_s == 0};
  endfunction

  // drive one clock of stimulus, advance the model and queue its expectation
  task automatic tick(input logic r, input logic en, input logic we, input logic [2:0] ch,
                      input logic [2:0] a, input logic [1:0] l, input logic p);
    logic cap;
    rst = r; clk_en = en; cfg_we = we; cfg_ch = ch; cfg_alg = a; cfg_rl = l; cfg_pcm = p;
    if (r) begin
      m_s = 0; m_busy = 0; m_pcm = 0;
      for (int i = 0; i < 6; i++) begin m_alg[i] = 3'd0; m_rl[i] = 2'b11; end
    end else begin
      cap = we && !m_busy && ch < 3'd6;
      if (en) begin
        m_s = (m_s + 1) % 24;
        if (m_busy && m_s == 6 + m_pch) begin
          m_alg[m_pch] = m_pa; m_rl[m_pch] = m_pl;
          if (m_pch == 5) m_pcm = m_pp;
          m_busy = 0;
        end
      end
      if (cap) begin m_busy = 1; m_pch = int'(ch); m_pa = a; m_pl = l; m_pp = p; end
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, 0, 0, 0, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset cyc %0d: got %h want %h", i, got, want); end
    end
    checks++;
    if ({s1_enters, s3_enters, frame_start, cfg_busy, alg, rl, pcm_en} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'b11, 1'b0}) begin
      errors++; $display("FAIL reset_defaults: got s1=%b s3=%b fs=%b busy=%b alg=%0d rl=%b pcm=%b", s1_enters, s3_enters, frame_start, cfg_busy, alg, rl, pcm_en);
    end
  endtask

  task automatic test_frame();
    int fs = 0, c6 = 0;
    for (int i = 0; i < 24; i++) begin
      tick(0, 1, 0, 0, 0, 0, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL frame slot %0d: got %h want %h", m_s, got, want); end
      fs += int'(frame_start); c6 += int'(ch6op);
    end
    checks++;
    if (fs != 1 || c6 != 4) begin errors++; $display("FAIL frame_counts: got fs=%0d ch6op=%0d want 1 and 4", fs, c6); end
  endtask

  task automatic test_write();
    logic sent = 0, w;
    for (int i = 0; i < 40; i++) begin
      w = m_s == 4 && !sent;
      if (w) sent = 1;
      tick(0, 1, w, 3'd2, 3'd5, 2'b01, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL write cyc %0d: got %h want %h", i, got, want); end
      if (m_s == 2 && !sent) begin
        checks++;
        if ({alg, rl} !== {3'd0, 2'b11}) begin errors++; $display("FAIL write_old: got alg=%0d rl=%b want 0 11", alg, rl); end
      end
      if (m_s == 8 && sent) begin
        checks++;
        if ({alg, rl, cfg_busy} !== {3'd5, 2'b01, 1'b0}) begin errors++; $display("FAIL write_commit: got alg=%0d rl=%b busy=%b want 5 01 0", alg, rl, cfg_busy); end
      end
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 56; i++) begin
      if (i == 0) tick(0, 1, 1, 3'd4, 3'd1, 2'b10, 0);
      else if (i == 1) tick(0, 1, 1, 3'd3, 3'd7, 2'b01, 0);
      else tick(0, 1, 0, 0, 0, 0, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL drop cyc %0d: got %h want %h", i, got, want); end
      if (cur_ch == 3'd3 && alg !== 3'd0) begin errors++; $display("FAIL drop_ch3: got alg=%0d want 0", alg); end
    end
    checks++;
  endtask

  task automatic test_pcm();
    for (int i = 0; i < 60; i++) begin
      if (i == 0) tick(0, 1, 1, 3'd5, 3'd2, 2'b11, 1);
      else if (i == 30) tick(0, 1, 1, 3'd1, 3'd4, 2'b10, 1);
      else tick(0, 1, 0, 0, 0, 0, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL pcm cyc %0d: got %h want %h", i, got, want); end
      if (pcm_en && cur_ch != 3'd5) begin errors++; $display("FAIL pcm_ch: got pcm_en=1 on ch %0d want 0", cur_ch); end
    end
    checks++;
  endtask

  task automatic test_boundary();
    logic sent = 0, w;
    int k = 0;
    for (int i = 0; i < 58; i++) begin
      w = m_s == 5 && !sent;
      if (w) sent = 1;
      else if (sent) k++;
      if (i == 52) tick(0, 1, 1, 3'd6, 3'd7, 2'b00, 1);
      else tick(0, 1, w, 3'd0, 3'd6, 2'b10, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL boundary cyc %0d: got %h want %h", i, got, want); end
      if (sent && k == 23) begin
        checks++;
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL boundary_wait: got busy=%b want 1", cfg_busy); end
      end
      if (sent && k == 24) begin
        checks++;
        if ({cfg_busy, alg, cur_ch, s3_enters} !== {1'b0, 3'd6, 3'd0, 1'b1}) begin
          errors++; $display("FAIL boundary_commit: got busy=%b alg=%0d ch=%0d s3=%b want 0 6 0 1", cfg_busy, alg, cur_ch, s3_enters);
        end
      end
      if (i == 52) begin
        checks++;
        if (cfg_busy !== 1'b0) begin errors++; $display("FAIL ch6_drop: got busy=%b want 0", cfg_busy); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 30 && m_s != 13; i++) begin
      tick(0, 1, m_s == 10, 3'd1, 3'd3, 2'b00, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL rstmid cyc %0d: got %h want %h", i, got, want); end
    end
    tick(1, 1, 0, 0, 0, 0, 0);
    got = sample(); want = sb.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL rstmid_reset: got %h want %h", got, want); end
    checks++;
    if ({cfg_busy, frame_start, s1_enters, cur_ch, alg, rl} !== {1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 2'b11}) begin
      errors++; $display("FAIL rstmid_defaults: got busy=%b fs=%b s1=%b ch=%0d alg=%0d rl=%b", cfg_busy, frame_start, s1_enters, cur_ch, alg, rl);
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 75; i++) begin
      tick(0, i % 3 == 0, i == 10, 3'd4, 3'd3, 2'b01, 0);
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL gapped cyc %0d: got %h want %h", i, got, want); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick($urandom_range(0, 99) == 0, 1'($urandom), $urandom_range(0, 7) == 0, 3'($urandom),
           3'($urandom), 2'($urandom), 1'($urandom));
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, got, want); end
    end
  endtask

  initial begin
    rst = 1; clk_en = 0; cfg_we = 0; cfg_ch = 0; cfg_alg = 0; cfg_rl = 0; cfg_pcm = 0;
    test_reset();
    test_frame();
    test_write();
    test_drop();
    test_pcm();
    test_boundary();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
